// File: rtl/alarm_fsm_param.sv
// Alarm-clock keypad entry controller with parameterised alarm slots and digits.
// Optional entry idle timeout is enabled by defining KEY_TIMEOUT_EN.
module alarm_fsm_param #(
    parameter int NUM_ALARMS    = 4,
    parameter int NUM_DIGITS    = 4,
    parameter int TIMEOUT_TICKS = 10,
    parameter int NOKEY         = 10,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
    localparam int DW = $clog2(NUM_DIGITS + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  one_second,
    input  logic                  time_button,
    input  logic                  alarm_button,
    input  logic [3:0]            key,
    input  logic [AW-1:0]         alarm_idx,
    output logic                  show_new_time,
    output logic                  show_a,
    output logic [AW-1:0]         alarm_sel,
    output logic [NUM_ALARMS-1:0] load_new_a,
    output logic                  load_new_c,
    output logic                  reset_count,
    output logic                  shift,
    output logic [DW-1:0]         digit_cnt,
    output logic                  time_out
);

    typedef enum logic [2:0] {
        SHOW_TIME,
        KEY_STORED,
        KEY_WAITED,
        KEY_ENTRY,
        SHOW_ALARM,
        SET_ALARM_TIME,
        SET_CURRENT_TIME
    } state_t;

    localparam logic [DW-1:0] DMAX = DW'(NUM_DIGITS);

    state_t        state_q, state_d;
    logic [AW-1:0] sel_q, sel_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          key_valid;
    logic          cnt_full;
    logic [AW-1:0] idx_ok;

    assign key_valid = (key <= 4'd9) && (int'(key) != NOKEY);
    assign cnt_full  = (cnt_q >= DMAX);
    assign idx_ok    = (int'(alarm_idx) < NUM_ALARMS) ? alarm_idx : '0;

`ifdef KEY_TIMEOUT_EN
    localparam logic [7:0] TMAX = 8'(TIMEOUT_TICKS);

    logic [7:0] tmr_q, tmr_d;
    logic       waiting;

    assign waiting = (state_q == KEY_WAITED) || (state_q == KEY_ENTRY);

    // A keypress restarts the idle window even before the FSM reacts.
    always_comb begin
        tmr_d = tmr_q;
        if (!waiting || key_valid) begin
            tmr_d = '0;
        end else if (one_second && (tmr_q != TMAX)) begin
            tmr_d = tmr_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end

    assign time_out = (tmr_q == TMAX);
`else
    logic unused_tick;
    assign unused_tick = one_second;
    assign time_out    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SHOW_TIME: begin
                cnt_d = '0;
                if (alarm_button) begin
                    state_d = SHOW_ALARM;
                    sel_d   = idx_ok;
                end else if (key_valid) begin
                    state_d = KEY_STORED;
                end
            end
            KEY_STORED: begin
                state_d = KEY_WAITED;
                if (!cnt_full) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            KEY_WAITED: begin
                if (!key_valid) begin
                    state_d = KEY_ENTRY;
                end else if (time_out) begin
                    state_d = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                if (alarm_button) begin
                    state_d = SET_ALARM_TIME;
                    sel_d   = idx_ok;
                end else if (time_button) begin
                    state_d = SET_CURRENT_TIME;
                end else if (key_valid && !cnt_full) begin
                    state_d = KEY_STORED;
                end else if (time_out) begin
                    state_d = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                if (!alarm_button) begin
                    state_d = SHOW_TIME;
                end
            end
            SET_ALARM_TIME:   state_d = SHOW_TIME;
            SET_CURRENT_TIME: state_d = SHOW_TIME;
            default:          state_d = SHOW_TIME;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= SHOW_TIME;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        show_new_time = 1'b0;
        show_a        = 1'b0;
        load_new_c    = 1'b0;
        reset_count   = 1'b0;
        shift         = 1'b0;
        load_new_a    = '0;
        unique case (state_q)
            KEY_STORED: begin
                show_new_time = 1'b1;
                shift         = 1'b1;
            end
            KEY_WAITED:     show_new_time = 1'b1;
            KEY_ENTRY:      show_new_time = 1'b1;
            SHOW_ALARM:     show_a = 1'b1;
            SET_ALARM_TIME: begin
                for (int i = 0; i < NUM_ALARMS; i++) begin
                    load_new_a[i] = (sel_q == AW'(i));
                end
            end
            SET_CURRENT_TIME: begin
                load_new_c  = 1'b1;
                reset_count = 1'b1;
            end
            default: ;
        endcase
    end

    assign alarm_sel = sel_q;
    assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_fsm_param.sv
// Randomised and directed bench for alarm_fsm_param against a behavioural model.
// Five alarm slots so that out-of-range slot indices are representable.
module tb_alarm_fsm_param;

    localparam int NA    = 5;
    localparam int ND    = 4;
    localparam int TICKS = 10;
    localparam logic [3:0] NK = 4'd10;

    localparam int M_IDLE  = 0;
    localparam int M_PRESS = 1;
    localparam int M_HOLD  = 2;
    localparam int M_READY = 3;
    localparam int M_VIEWA = 4;
    localparam int M_SAVEA = 5;
    localparam int M_SAVEC = 6;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       one_second = 1'b0;
    logic       time_button = 1'b0;
    logic       alarm_button = 1'b0;
    logic [3:0] key = NK;
    logic [2:0] alarm_idx = '0;
    logic       show_new_time, show_a, load_new_c, reset_count;
    logic       shift, time_out;
    logic [2:0] alarm_sel;
    logic [4:0] load_new_a;
    logic [2:0] digit_cnt;

    int errors = 0;
    int checks = 0;

    int m_st, m_cnt, m_sel, m_tmr;

    alarm_fsm_param #(
        .NUM_ALARMS(NA),
        .NUM_DIGITS(ND),
        .TIMEOUT_TICKS(TICKS),
        .NOKEY(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .one_second(one_second),
        .time_button(time_button),
        .alarm_button(alarm_button),
        .key(key),
        .alarm_idx(alarm_idx),
        .show_new_time(show_new_time),
        .show_a(show_a),
        .alarm_sel(alarm_sel),
        .load_new_a(load_new_a),
        .load_new_c(load_new_c),
        .reset_count(reset_count),
        .shift(shift),
        .digit_cnt(digit_cnt),
        .time_out(time_out)
    );

    always #5 clock = ~clock;

    logic [16:0] act;
    assign act = {show_new_time, show_a, alarm_sel, load_new_a, load_new_c,
                  reset_count, shift, digit_cnt, time_out};

    task automatic model_reset();
        m_st  = M_IDLE;
        m_cnt = 0;
        m_sel = 0;
        m_tmr = 0;
    endtask

    function automatic int slot_of(input int idx);
        return (idx < NA) ? idx : 0;
    endfunction

    task automatic model_step();
        int  n_st, n_cnt, n_sel, n_tmr;
        bit  kv, to;
        if (reset) begin
            model_reset();
            return;
        end
        kv = (key <= 4'd9);
        to = 1'b0;
`ifdef KEY_TIMEOUT_EN
        to = (m_tmr == TICKS);
`endif
        n_st  = m_st;
        n_cnt = m_cnt;
        n_sel = m_sel;
        n_tmr = 0;
        if ((m_st == M_HOLD || m_st == M_READY) && !kv)
            n_tmr = (one_second && m_tmr < TICKS) ? m_tmr + 1 : m_tmr;
        case (m_st)
            M_IDLE: begin
                n_cnt = 0;
                if (alarm_button) begin
                    n_st  = M_VIEWA;
                    n_sel = slot_of(int'(alarm_idx));
                end else if (kv) n_st = M_PRESS;
            end
            M_PRESS: begin
                n_st  = M_HOLD;
                n_cnt = (m_cnt < ND) ? m_cnt + 1 : ND;
            end
            M_HOLD: begin
                if (!kv) n_st = M_READY;
                else if (to) n_st = M_IDLE;
            end
            M_READY: begin
                if (alarm_button) begin
                    n_st  = M_SAVEA;
                    n_sel = slot_of(int'(alarm_idx));
                end else if (time_button) n_st = M_SAVEC;
                else if (kv && m_cnt < ND) n_st = M_PRESS;
                else if (to) n_st = M_IDLE;
            end
            M_VIEWA: if (!alarm_button) n_st = M_IDLE;
            default: n_st = M_IDLE;
        endcase
        m_st  = n_st;
        m_cnt = n_cnt;
        m_sel = n_sel;
        m_tmr = n_tmr;
    endtask

    function automatic logic [16:0] exp_vec();
        logic       snt, sa, lc, sh, to;
        logic [4:0] la;
        snt = (m_st == M_PRESS || m_st == M_HOLD || m_st == M_READY);
        sa  = (m_st == M_VIEWA);
        lc  = (m_st == M_SAVEC);
        sh  = (m_st == M_PRESS);
        la  = (m_st == M_SAVEA) ? (5'b00001 << m_sel) : 5'b0;
        to  = 1'b0;
`ifdef KEY_TIMEOUT_EN
        to = (m_tmr == TICKS);
`endif
        return {snt, sa, 3'(m_sel), la, lc, lc, sh, 3'(m_cnt), to};
    endfunction

    task automatic cyc(input logic ab, input logic tbt, input logic [3:0] k,
                       input logic os, input logic [2:0] idx,
                       input logic rst = 1'b0);
        alarm_button = ab;
        time_button  = tbt;
        key          = k;
        one_second   = os;
        alarm_idx    = idx;
        reset        = rst;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic enter_digit(input logic [3:0] k);
        cyc(0, 0, k, 0, 0);
        cyc(0, 0, NK, 0, 0);
        cyc(0, 0, NK, 0, 0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        model_reset();
        checks++;
        if (act !== 17'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", act, 17'd0);
        end
        reset = 1'b0;
        enter_digit(4'd1);
        enter_digit(4'd2);
        checks++;
        if (digit_cnt !== 3'd2 || show_new_time !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_entry: cnt=%0d snt=%b want 2/1",
                     digit_cnt, show_new_time);
        end
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (act !== 17'd0) begin
            errors++;
            $display("FAIL async_reset_mid_entry: got %h want %h", act, 17'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        cyc(0, 0, NK, 0, 0);
        checks++;
        if (act !== exp_vec() || show_new_time !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_alarm_load();
        int shifts = 0;
        cyc(0, 0, 4'd3, 0, 0);
        if (shift) shifts++;
        cyc(0, 0, NK, 0, 0);
        if (shift) shifts++;
        cyc(0, 0, NK, 0, 0);
        cyc(1, 0, NK, 0, 3'd2);
        checks++;
        if (load_new_a !== 5'b00100 || alarm_sel !== 3'd2 || shifts != 1) begin
            errors++;
            $display("FAIL alarm_load: la=%b sel=%0d shifts=%0d want 00100/2/1",
                     load_new_a, alarm_sel, shifts);
        end
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL alarm_load_model: got %h want %h", act, exp_vec());
        end
        cyc(0, 0, NK, 0, 0);
        checks++;
        if (load_new_a !== 5'b0 || act !== exp_vec()) begin
            errors++;
            $display("FAIL alarm_load_one_cycle: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_digit_limit();
        int shifts = 0;
        for (int p = 0; p < 5; p++) begin
            cyc(0, 0, 4'(p + 1), 0, 0);
            if (shift) shifts++;
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL digit_press_%0d: got %h want %h", p, act, exp_vec());
            end
            cyc(0, 0, NK, 0, 0);
            if (shift) shifts++;
            cyc(0, 0, NK, 0, 0);
        end
        checks++;
        if (shifts != 4 || digit_cnt !== 3'd4 || show_new_time !== 1'b1) begin
            errors++;
            $display("FAIL digit_limit: shifts=%0d cnt=%0d snt=%b want 4/4/1",
                     shifts, digit_cnt, show_new_time);
        end
        cyc(0, 1, NK, 0, 0);
        checks++;
        if (load_new_c !== 1'b1 || reset_count !== 1'b1) begin
            errors++;
            $display("FAIL set_time: lc=%b rc=%b want 1/1", load_new_c, reset_count);
        end
        cyc(0, 0, NK, 0, 0);
        checks++;
        if (act !== exp_vec() || show_new_time !== 1'b0) begin
            errors++;
            $display("FAIL set_time_return: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_timeout();
        logic want_to;
`ifdef KEY_TIMEOUT_EN
        want_to = 1'b1;
`else
        want_to = 1'b0;
`endif
        enter_digit(4'd7);
        for (int t = 0; t < TICKS; t++) begin
            checks++;
            if (time_out !== 1'b0) begin
                errors++;
                $display("FAIL timeout_early_%0d: got %b want 0", t, time_out);
            end
            cyc(0, 0, NK, 1, 0);
        end
        checks++;
        if (time_out !== want_to || show_new_time !== 1'b1) begin
            errors++;
            $display("FAIL timeout_reached: to=%b snt=%b want %b/1",
                     time_out, show_new_time, want_to);
        end
        cyc(0, 0, NK, 0, 0);
        checks++;
        if (show_new_time !== !want_to || act !== exp_vec()) begin
            errors++;
            $display("FAIL timeout_exit: got %h want %h", act, exp_vec());
        end
        cyc(0, 1, NK, 0, 0);
        cyc(0, 0, NK, 0, 0);
    endtask

    task automatic test_both_buttons();
        enter_digit(4'd4);
        cyc(1, 1, NK, 0, 3'd1);
        checks++;
        if (load_new_c !== 1'b0 || reset_count !== 1'b0 ||
            load_new_a !== 5'b00010) begin
            errors++;
            $display("FAIL both_buttons: lc=%b rc=%b la=%b want 0/0/00010",
                     load_new_c, reset_count, load_new_a);
        end
        cyc(0, 0, NK, 0, 0);
    endtask

    task automatic test_bad_index();
        cyc(1, 0, NK, 0, 3'd3);
        cyc(0, 0, NK, 0, 0);
        cyc(1, 0, NK, 0, 3'd7);
        checks++;
        if (show_a !== 1'b1 || alarm_sel !== 3'd0) begin
            errors++;
            $display("FAIL bad_index_7: show_a=%b sel=%0d want 1/0", show_a, alarm_sel);
        end
        cyc(1, 0, NK, 0, 3'd3);
        checks++;
        if (show_a !== 1'b1 || alarm_sel !== 3'd0) begin
            errors++;
            $display("FAIL sel_hold: show_a=%b sel=%0d want 1/0", show_a, alarm_sel);
        end
        cyc(0, 0, NK, 0, 0);
        cyc(1, 0, NK, 0, 3'd4);
        cyc(0, 0, NK, 0, 0);
        cyc(1, 0, NK, 0, 3'd5);
        checks++;
        if (alarm_sel !== 3'd0 || act !== exp_vec()) begin
            errors++;
            $display("FAIL bad_index_5: got %h want %h", act, exp_vec());
        end
        cyc(0, 0, NK, 0, 0);
    endtask

    task automatic test_random();
        logic       ab, tbt, os, rst;
        logic [3:0] k;
        logic [2:0] idx;
        int         bad = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n < 1500) begin
                ab = ($urandom_range(0, 7) == 0);
                tbt = ($urandom_range(0, 7) == 0);
                k = ($urandom_range(0, 1) == 0) ? NK : 4'($urandom_range(0, 15));
            end else begin
                ab = ($urandom_range(0, 39) == 0);
                tbt = ($urandom_range(0, 39) == 0);
                k = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(0, 15)) : NK;
            end
            os  = ($urandom_range(0, 2) == 0);
            idx = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 299) == 0);
            cyc(ab, tbt, k, os, idx, rst);
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random_cycle_%0d: got %h want %h", n, act, exp_vec());
            end
        end
        cyc(0, 0, NK, 0, 0);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_alarm_load();
        test_digit_limit();
        test_timeout();
        test_both_buttons();
        test_bad_index();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
